// File: rtl/iexu_multicycle_alu.sv
// Integer execution unit: single-cycle add/sub/logic, iterative shifts of SHIFT_STEP bits per cycle.
// Optional feature macro IEXU_SLT_EN enables slt (op 8) and sltu (op 9).
module iexu_multicycle_alu #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] STEP_SW = SW'(SHIFT_STEP % XLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] shreg_q;
  logic [XLEN-1:0] result_q;
  logic [SW-1:0]   rem_q;
  logic [1:0]      kind_q;
  logic            sign_q;
  logic            out_valid_q;
  logic            illegal_q;

  logic            accept;
  logic            is_shift;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [SW-1:0]   step;
  logic [SW-1:0]   rem_nxt;
  logic [2*XLEN-1:0] sra_ext;
  logic [XLEN-1:0] shifted;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready never depends on in_valid; flush always wins over a same-cycle accept.
  assign in_ready  = !flush & ((state_q == IDLE) | ((state_q == RESP) & out_ready));
  assign accept    = in_valid & in_ready;
  assign shamt     = op_b[SW-1:0];
  assign is_shift  = (op == 4'd5) | (op == 4'd6) | (op == 4'd7);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5, 4'd6, 4'd7: alu_res = op_a;  // only used when shamt is zero
`ifdef IEXU_SLT_EN
      4'd8: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Per-cycle shift amount is min(SHIFT_STEP, remaining); sra fills from the latched sign.
  assign step    = (int'(rem_q) < SHIFT_STEP) ? rem_q : STEP_SW;
  assign rem_nxt = rem_q - step;
  assign sra_ext = {{XLEN{sign_q}}, shreg_q} >> step;

  always_comb begin
    shifted = shreg_q;
    case (kind_q)
      2'd1:    shifted = shreg_q << step;
      2'd2:    shifted = shreg_q >> step;
      default: shifted = sra_ext[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      shreg_q     <= '0;
      rem_q       <= '0;
      kind_q      <= 2'd0;
      sign_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          shreg_q <= shifted;
          rem_q   <= rem_nxt;
          if (rem_nxt == '0) begin
            state_q     <= RESP;
            out_valid_q <= 1'b1;
            result_q    <= shifted;
            illegal_q   <= 1'b0;
          end
        end
        IDLE, RESP: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state_q     <= SHIFT;
              out_valid_q <= 1'b0;
              shreg_q     <= op_a;
              rem_q       <= shamt;
              kind_q      <= op[1:0];
              sign_q      <= op_a[XLEN-1];
            end else begin
              state_q     <= RESP;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              illegal_q   <= alu_ill;
            end
          end else if ((state_q == RESP) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
